if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and drives a single-outstanding-request instruction-memory handshake.
- Presents instrCode / PC / PC_4 with a valid flag to the IF/ID register.
- Honours hazard-unit stall and EX-stage redirect (branch/jump), discarding wrong-path fetches.

---
 rtl/if_fetch_stage.sv | 106 ++++++++++
 tb/tb_if_fetch_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and keeps at most one
// instruction-memory request in flight. Each accepted response is presented
// to the IF/ID register as instrCode/PC/PC_4 with instr_valid. Responses
// that belong to a path abandoned by an EX-stage redirect are discarded.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrCode,
  output logic [31:0] PC,
  output logic [31:0] PC_4,
  output logic        instr_valid
);

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic        drop;
  logic        accept;
  logic        take_resp;
  logic [31:0] redirect_target;

  // Request only when the output slot is free or drains this cycle, so a
  // response can always be written; redirect deliberately has no say here.
  assign imem_req        = (state == FETCH) && (!instr_valid || !stall) && !rst;
  assign imem_addr       = pc_q;
  assign accept          = imem_req && imem_ready;
  assign take_resp       = (state == WAIT) && imem_rvalid && !drop && !redirect_valid;
  // Masking keeps the target word aligned while still reading every input bit.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Fetch FSM, PC update, wrong-path drop tracking and output register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so later statements in this
    // block override earlier ones (redirect last = highest priority) and every
    // read sees the value from before the clock edge.
    if (rst) begin
      state       <= FETCH;
      pc_q        <= RESET_PC;
      req_pc      <= 32'h0;
      drop        <= 1'b0;
      instrCode   <= 32'h0;
      PC          <= 32'h0;
      PC_4        <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      // Downstream consumed the presented instruction.
      if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
      end

      unique case (state)
        FETCH: begin
          if (accept) begin
            req_pc <= pc_q;
            pc_q   <= pc_q + 32'd4;
            state  <= WAIT;
            // The request just accepted is already on the wrong path.
            if (redirect_valid) begin
              drop <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state <= FETCH;
            if (take_resp) begin
              instrCode   <= imem_rdata;
              PC          <= req_pc;
              PC_4        <= req_pc + 32'd4;
              instr_valid <= 1'b1;
            end else begin
              drop <= 1'b0;
            end
          end else if (redirect_valid) begin
            // Only one request can be outstanding, so one drop flag suffices
            // even if several redirects arrive before it returns.
            drop <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase

      // Redirect overrides both the sequential PC and any live output.
      if (redirect_valid) begin
        pc_q        <= redirect_target;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a per-cycle vector table covering
// streaming, stall, redirects, collisions, backpressure and PC wrap, followed
// by a hand-written reset-during-WAIT sequence.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrCode;
  logic [31:0] PC;
  logic [31:0] PC_4;
  logic        instr_valid;

  int total = 0;
  int bad   = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instrCode      (instrCode),
    .PC             (PC),
    .PC_4           (PC_4),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  // One cycle: inputs applied at negedge; expected values are what the DUT
  // shows 1 ns later (imem_req/addr for this cycle, registered outputs from
  // the previous edge).
  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rval;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic rval, input logic [31:0] rdata);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    imem_rvalid    = rval;
    imem_rdata     = rdata;
  endtask

  initial begin
    //         stall rv  rpc            rdy  rval rdata          req  addr           iv   pc             pc4            instr
    vecs[0]  = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          32'h0,          32'h0};
    vecs[1]  = '{0, 0, 32'h0,          1, 1, 32'hA5A5_0000,  0, 32'h0000_0004, 0, 32'h0,          32'h0,          32'h0};
    vecs[2]  = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h0,          32'h4,          32'hA5A5_0000};
    vecs[3]  = '{0, 0, 32'h0,          1, 1, 32'hA5A5_0004,  0, 32'h0000_0008, 0, 32'h0,          32'h4,          32'hA5A5_0000};
    vecs[4]  = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h4,          32'h8,          32'hA5A5_0004};
    vecs[5]  = '{0, 0, 32'h0,          1, 1, 32'hA5A5_0008,  0, 32'h0000_000C, 0, 32'h4,          32'h8,          32'hA5A5_0004};
    // stall for 4 cycles while PC=8 is presented
    vecs[6]  = '{1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h8,          32'hC,          32'hA5A5_0008};
    vecs[7]  = '{1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h8,          32'hC,          32'hA5A5_0008};
    vecs[8]  = '{1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h8,          32'hC,          32'hA5A5_0008};
    vecs[9]  = '{1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h8,          32'hC,          32'hA5A5_0008};
    vecs[10] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_000C, 1, 32'h8,          32'hC,          32'hA5A5_0008};
    vecs[11] = '{0, 0, 32'h0,          1, 1, 32'hA5A5_000C,  0, 32'h0000_0010, 0, 32'h8,          32'hC,          32'hA5A5_0008};
    vecs[12] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0010, 1, 32'hC,          32'h10,         32'hA5A5_000C};
    // redirect while WAIT on 0x10, then stale response dropped
    vecs[13] = '{0, 1, 32'h100,        1, 0, 32'h0,          0, 32'h0000_0014, 0, 32'hC,          32'h10,         32'hA5A5_000C};
    vecs[14] = '{0, 0, 32'h0,          1, 1, 32'hDEAD_BEEF,  0, 32'h0000_0100, 0, 32'hC,          32'h10,         32'hA5A5_000C};
    vecs[15] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0100, 0, 32'hC,          32'h10,         32'hA5A5_000C};
    vecs[16] = '{0, 0, 32'h0,          1, 1, 32'hA5A5_0100,  0, 32'h0000_0104, 0, 32'hC,          32'h10,         32'hA5A5_000C};
    vecs[17] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0104, 1, 32'h100,        32'h104,        32'hA5A5_0100};
    // redirect in same cycle as rvalid
    vecs[18] = '{0, 1, 32'h20,         1, 1, 32'h1111_1111,  0, 32'h0000_0108, 0, 32'h100,        32'h104,        32'hA5A5_0100};
    // redirect in same cycle as accept at 0x20, unaligned target 0x203
    vecs[19] = '{0, 1, 32'h203,        1, 0, 32'h0,          1, 32'h0000_0020, 0, 32'h100,        32'h104,        32'hA5A5_0100};
    vecs[20] = '{0, 0, 32'h0,          1, 1, 32'h2222_2222,  0, 32'h0000_0200, 0, 32'h100,        32'h104,        32'hA5A5_0100};
    // backpressure for 3 cycles
    vecs[21] = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0200, 0, 32'h100,        32'h104,        32'hA5A5_0100};
    vecs[22] = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0200, 0, 32'h100,        32'h104,        32'hA5A5_0100};
    vecs[23] = '{0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0200, 0, 32'h100,        32'h104,        32'hA5A5_0100};
    vecs[24] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0200, 0, 32'h100,        32'h104,        32'hA5A5_0100};
    vecs[25] = '{0, 0, 32'h0,          1, 1, 32'hA5A5_0200,  0, 32'h0000_0204, 0, 32'h100,        32'h104,        32'hA5A5_0100};
    // redirect to last word (not accepted: ready=0), then wrap
    vecs[26] = '{0, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          1, 32'h0000_0204, 1, 32'h200,        32'h204,        32'hA5A5_0200};
    vecs[27] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h200,        32'h204,        32'hA5A5_0200};
    vecs[28] = '{0, 0, 32'h0,          1, 1, 32'h5A5A_FFFC,  0, 32'h0000_0000, 0, 32'h200,        32'h204,        32'hA5A5_0200};
    vecs[29] = '{0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0000, 1, 32'hFFFF_FFFC,  32'h0,          32'h5A5A_FFFC};
    // now WAIT on 0x0 with pc_q=4
    vecs[30] = '{0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0004, 0, 32'hFFFF_FFFC,  32'h0,          32'h5A5A_FFFC};

    // Reset for two cycles.
    rst = 1'b1;
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk);
    #1 check("req_in_reset", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", {31'b0, instr_valid}, 32'h0);
    check("reset_pc", PC, 32'h0);
    check("reset_pc4", PC_4, 32'h0);
    check("reset_instr", instrCode, 32'h0);
    check("reset_addr", imem_addr, 32'h0);

    // The first vector shares this negedge with reset release.
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rval, vecs[i].rdata);
      #1;
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_iv});
      check($sformatf("v%0d_pc", i), PC, vecs[i].e_pc);
      check($sformatf("v%0d_pc4", i), PC_4, vecs[i].e_pc4);
      check($sformatf("v%0d_instr", i), instrCode, vecs[i].e_instr);
    end

    // Reset while a request to 0x0 is outstanding; its late response must be ignored.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1 check("midrst_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 1, 32'h3333_3333);
    #1;
    check("midrst_pc", PC, 32'h0);
    check("midrst_instr", instrCode, 32'h0);
    check("midrst_req_after", {31'b0, imem_req}, 32'h1);
    check("midrst_addr", imem_addr, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    check("late_resp_valid", {31'b0, instr_valid}, 32'h0);
    check("late_resp_instr", instrCode, 32'h0);
    check("late_resp_req", {31'b0, imem_req}, 32'h1);
    check("late_resp_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
